// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Bundle between the pipeline datapath and the hazard controller.
//
//   Hazard sources (pipeline -> controller):
//     rs1_ID, rs2_ID            [4:0]  source register indices of the ID instruction
//     uses_rs1_ID, uses_rs2_ID         ID instruction actually reads that source
//     MemRead_EX                       EX instruction is a load
//     wrin_EX                   [4:0]  destination register of the EX instruction
//     branch_taken_EX                  branch in EX resolved taken
//     mem_req_MEM, mem_ready_MEM       data-memory request / ready handshake
//
//   Pipeline controls (controller -> pipeline):
//     PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE   stage-register load enables
//     IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH             bubble insertion on next edge
//     mem_err                                            one-cycle memory timeout pulse
//     stall_count, flush_count  [15:0]                   optional statistics
//
//   Modports: master = pipeline side, slave = hazard controller.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
    logic [4:0]  rs1_ID;
    logic [4:0]  rs2_ID;
    logic        uses_rs1_ID;
    logic        uses_rs2_ID;
    logic        MemRead_EX;
    logic [4:0]  wrin_EX;
    logic        branch_taken_EX;
    logic        mem_req_MEM;
    logic        mem_ready_MEM;

    logic        PC_WRITE;
    logic        IF_ID_WRITE;
    logic        ID_EX_WRITE;
    logic        EX_MEM_WRITE;
    logic        IF_ID_FLUSH;
    logic        ID_EX_FLUSH;
    logic        MEM_WB_FLUSH;
    logic        mem_err;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    modport master (
        output rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID,
        output MemRead_EX, wrin_EX, branch_taken_EX,
        output mem_req_MEM, mem_ready_MEM,
        input  PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE,
        input  IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH,
        input  mem_err, stall_count, flush_count
    );

    modport slave (
        input  rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID,
        input  MemRead_EX, wrin_EX, branch_taken_EX,
        input  mem_req_MEM, mem_ready_MEM,
        output PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE,
        output IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH,
        output mem_err, stall_count, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard controller for a 5-stage in-order pipeline. Resolves three hazard
//   classes with fixed priority: data-memory wait > taken branch > load-use.
//
//   Parameters:
//     FLUSH_CYCLES (1..7)    total cycles IF/ID is flushed after a taken branch
//     MEM_TIMEOUT  (1..1023) MEM_WAIT cycles tolerated before aborting with mem_err
//
//   Ports:
//     CLK    single clock, rising edge
//     RESET  asynchronous, active-high; outputs are forced to the "everything
//            frozen and bubbled" pattern while it is high
//     bus    pipe_hazard_ctrl_if.slave (hazard sources in, stage controls out)
//
//   All controls are combinational from the current state and inputs.
//
//   Build option: define PIPE_HAZARD_STATS_EN to get saturating stall/flush
//   counters; otherwise stall_count/flush_count are tied to zero.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic               CLK,
    input  logic               RESET,
    pipe_hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_FLUSH    = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam logic [9:0] TIMEOUT_LIM = 10'(MEM_TIMEOUT);
    localparam logic       MULTI_FLUSH = (FLUSH_CYCLES > 1);

    state_t     state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [9:0] to_cnt_q, to_cnt_d;

    logic mem_wait;
    logic load_use;

    // Event selected for this cycle (at most one is set).
    logic enter_wait, hold_wait, take_branch, stall_lu, flushing, timeout;

    logic pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic if_id_flush, id_ex_flush, mem_wb_flush, mem_err_c;

    assign mem_wait = bus.mem_req_MEM & ~bus.mem_ready_MEM;

    // x0 is hard-wired to zero, so a load targeting it can never feed ID.
    assign load_use = bus.MemRead_EX && (bus.wrin_EX != 5'd0) &&
                      ((bus.uses_rs1_ID && (bus.rs1_ID == bus.wrin_EX)) ||
                       (bus.uses_rs2_ID && (bus.rs2_ID == bus.wrin_EX)));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_RUN;
            flush_cnt_q <= 3'd0;
            to_cnt_q    <= 10'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        mem_err_c    = 1'b0;
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        to_cnt_d     = to_cnt_q;
        enter_wait   = 1'b0;
        hold_wait    = 1'b0;
        take_branch  = 1'b0;
        stall_lu     = 1'b0;
        flushing     = 1'b0;
        timeout      = 1'b0;

        // Event selection by state and priority.
        case (state_q)
            S_RUN: begin
                if (mem_wait)                 enter_wait  = 1'b1;
                else if (bus.branch_taken_EX) take_branch = 1'b1;
                else if (load_use)            stall_lu    = 1'b1;
            end
            S_FLUSH: begin
                // Load-use is meaningless here: ID holds an instruction being flushed.
                if (mem_wait) enter_wait = 1'b1;
                else          flushing   = 1'b1;
            end
            S_MEM_WAIT: begin
                if (bus.mem_ready_MEM) begin
                    // EX was frozen during the wait, so the branch / load-use
                    // inputs seen now are the ones deferred by the wait.
                    state_d  = S_RUN;
                    to_cnt_d = 10'd0;
                    if (bus.branch_taken_EX) take_branch = 1'b1;
                    else if (load_use)       stall_lu    = 1'b1;
                end else if (to_cnt_q >= TIMEOUT_LIM) begin
                    timeout = 1'b1;
                end else begin
                    hold_wait = 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase

        // Freeze the whole pipe and bubble MEM/WB while memory is not ready.
        if (enter_wait || hold_wait) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
            state_d      = S_MEM_WAIT;
            flush_cnt_d  = 3'd0;
            to_cnt_d     = enter_wait ? 10'd1 : (to_cnt_q + 10'd1);
        end

        // This cycle counts as the first of FLUSH_CYCLES flush cycles.
        if (take_branch) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            to_cnt_d    = 10'd0;
            if (MULTI_FLUSH) begin
                state_d     = S_FLUSH;
                flush_cnt_d = FLUSH_LOAD;
            end else begin
                state_d = S_RUN;
            end
        end

        if (stall_lu) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end

        if (flushing) begin
            if_id_flush = 1'b1;
            flush_cnt_d = flush_cnt_q - 3'd1;
            if (flush_cnt_q <= 3'd1) begin
                state_d     = S_RUN;
                flush_cnt_d = 3'd0;
            end
        end

        if (timeout) begin
            mem_err_c = 1'b1;
            state_d   = S_RUN;
            to_cnt_d  = 10'd0;
        end

        // Reset dominates: nothing advances and every stage gets a bubble.
        if (RESET) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
            mem_err_c    = 1'b0;
        end
    end

    assign bus.PC_WRITE     = pc_write;
    assign bus.IF_ID_WRITE  = if_id_write;
    assign bus.ID_EX_WRITE  = id_ex_write;
    assign bus.EX_MEM_WRITE = ex_mem_write;
    assign bus.IF_ID_FLUSH  = if_id_flush;
    assign bus.ID_EX_FLUSH  = id_ex_flush;
    assign bus.MEM_WB_FLUSH = mem_wb_flush;
    assign bus.mem_err      = mem_err_c;

`ifdef PIPE_HAZARD_STATS_EN
    logic [15:0] stall_stat_q;
    logic [15:0] flush_stat_q;

    // Saturating event counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_stat_q <= 16'd0;
            flush_stat_q <= 16'd0;
        end else begin
            if (!pc_write && (stall_stat_q != 16'hFFFF))
                stall_stat_q <= stall_stat_q + 16'd1;
            if (if_id_flush && (flush_stat_q != 16'hFFFF))
                flush_stat_q <= flush_stat_q + 16'd1;
        end
    end

    assign bus.stall_count = stall_stat_q;
    assign bus.flush_count = flush_stat_q;
`else
    assign bus.stall_count = 16'd0;
    assign bus.flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Instance A uses FLUSH_CYCLES=3 and
//   MEM_TIMEOUT=8; instance B uses FLUSH_CYCLES=2 for the statistics scenario.
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
//   Output vectors are packed as {PC_WRITE, IF_ID_WRITE, ID_EX_WRITE,
//   EX_MEM_WRITE, IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH, mem_err}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam logic [7:0] O_RUN = 8'b1111_0000;
    localparam logic [7:0] O_RST = 8'b0000_1110;
    localparam logic [7:0] O_MW  = 8'b0000_0010;
    localparam logic [7:0] O_BR  = 8'b1111_1100;
    localparam logic [7:0] O_FL  = 8'b1111_1000;
    localparam logic [7:0] O_LU  = 8'b0011_0100;
    localparam logic [7:0] O_TO  = 8'b1111_0001;

    typedef struct packed {
        logic       rst;
        logic       br;
        logic       lu;
        logic       mreq;
        logic       mrdy;
        logic [7:0] exp;
    } row_t;

    typedef struct packed {
        logic       mr;
        logic [4:0] wr;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [7:0] exp;
    } lu_row_t;

    logic CLK;
    logic RESET;
    int   n_tests;
    int   n_fail;

    pipe_hazard_ctrl_if bus_a ();
    pipe_hazard_ctrl_if bus_b ();

    pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(8)) u_dut_a (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_a)
    );

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(255)) u_dut_b (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_b)
    );

    wire [7:0] outs_a = {bus_a.PC_WRITE, bus_a.IF_ID_WRITE, bus_a.ID_EX_WRITE, bus_a.EX_MEM_WRITE,
                         bus_a.IF_ID_FLUSH, bus_a.ID_EX_FLUSH, bus_a.MEM_WB_FLUSH, bus_a.mem_err};
    wire [7:0] outs_b = {bus_b.PC_WRITE, bus_b.IF_ID_WRITE, bus_b.ID_EX_WRITE, bus_b.EX_MEM_WRITE,
                         bus_b.IF_ID_FLUSH, bus_b.ID_EX_FLUSH, bus_b.MEM_WB_FLUSH, bus_b.mem_err};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic row_t mk(input logic rst, input logic br, input logic lu,
                                input logic mreq, input logic mrdy, input logic [7:0] exp);
        row_t r;
        r.rst = rst; r.br = br; r.lu = lu; r.mreq = mreq; r.mrdy = mrdy; r.exp = exp;
        return r;
    endfunction

    task automatic drive_a(input row_t r);
        RESET                 = r.rst;
        bus_a.branch_taken_EX = r.br;
        bus_a.MemRead_EX      = r.lu;
        bus_a.wrin_EX         = 5'd5;
        bus_a.rs1_ID          = 5'd3;
        bus_a.uses_rs1_ID     = 1'b1;
        bus_a.rs2_ID          = 5'd5;
        bus_a.uses_rs2_ID     = 1'b1;
        bus_a.mem_req_MEM     = r.mreq;
        bus_a.mem_ready_MEM   = r.mrdy;
    endtask

    task automatic drive_b(input row_t r);
        bus_b.branch_taken_EX = r.br;
        bus_b.MemRead_EX      = r.lu;
        bus_b.wrin_EX         = 5'd6;
        bus_b.rs1_ID          = 5'd6;
        bus_b.uses_rs1_ID     = 1'b1;
        bus_b.rs2_ID          = 5'd1;
        bus_b.uses_rs2_ID     = 1'b0;
        bus_b.mem_req_MEM     = r.mreq;
        bus_b.mem_ready_MEM   = r.mrdy;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        drive_a(mk(1, 0, 0, 0, 0, O_RST));
        drive_b(mk(1, 0, 0, 0, 0, O_RST));
        repeat (2) @(negedge CLK);
        #1;
        n_tests++;
        if (outs_a !== O_RST) begin
            n_fail++; $display("FAIL reset_outs_a: got %b expected %b", outs_a, O_RST);
        end
        n_tests++;
        if (outs_b !== O_RST) begin
            n_fail++; $display("FAIL reset_outs_b: got %b expected %b", outs_b, O_RST);
        end
        n_tests++;
        if (bus_a.stall_count !== 16'd0 || bus_a.flush_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_counts: got stall=%0d flush=%0d expected 0/0",
                               bus_a.stall_count, bus_a.flush_count);
        end
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        n_tests++;
        if (outs_a !== O_RUN) begin
            n_fail++; $display("FAIL reset_release: got %b expected %b", outs_a, O_RUN);
        end
        @(negedge CLK);
        #1;
        n_tests++;
        if (outs_a !== O_RUN) begin
            n_fail++; $display("FAIL first_run_cycle: got %b expected %b", outs_a, O_RUN);
        end
    endtask

    task automatic test_load_use();
        lu_row_t v[$];
        v.push_back('{1'b1, 5'd5,  5'd3,  1'b1, 5'd5,  1'b1, O_LU});
        v.push_back('{1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, O_RUN});
        v.push_back('{1'b1, 5'd0,  5'd3,  1'b1, 5'd5,  1'b1, O_RUN});
        v.push_back('{1'b1, 5'd0,  5'd0,  1'b1, 5'd0,  1'b1, O_RUN});
        v.push_back('{1'b1, 5'd7,  5'd7,  1'b1, 5'd2,  1'b0, O_LU});
        v.push_back('{1'b1, 5'd7,  5'd2,  1'b1, 5'd7,  1'b0, O_RUN});
        v.push_back('{1'b0, 5'd7,  5'd7,  1'b1, 5'd7,  1'b1, O_RUN});
        v.push_back('{1'b1, 5'd9,  5'd9,  1'b0, 5'd9,  1'b0, O_RUN});
        v.push_back('{1'b1, 5'd31, 5'd31, 1'b1, 5'd31, 1'b1, O_LU});
        v.push_back('{1'b1, 5'd12, 5'd4,  1'b1, 5'd13, 1'b1, O_RUN});
        for (int i = 0; i < v.size(); i++) begin
            @(negedge CLK);
            drive_a(mk(0, 0, 0, 0, 0, O_RUN));
            bus_a.MemRead_EX  = v[i].mr;
            bus_a.wrin_EX     = v[i].wr;
            bus_a.rs1_ID      = v[i].rs1;
            bus_a.uses_rs1_ID = v[i].u1;
            bus_a.rs2_ID      = v[i].rs2;
            bus_a.uses_rs2_ID = v[i].u2;
            #1;
            n_tests++;
            if (outs_a !== v[i].exp) begin
                n_fail++; $display("FAIL load_use[%0d]: got %b expected %b", i, outs_a, v[i].exp);
            end
        end
    endtask

    task automatic test_branch();
        row_t q[$];
        q.push_back(mk(0, 1, 0, 0, 0, O_BR));
        q.push_back(mk(0, 0, 1, 0, 0, O_FL));
        q.push_back(mk(0, 0, 0, 0, 0, O_FL));
        q.push_back(mk(0, 0, 0, 0, 0, O_RUN));
        q.push_back(mk(0, 0, 1, 0, 0, O_LU));
        q.push_back(mk(0, 0, 0, 0, 0, O_RUN));
        for (int i = 0; i < q.size(); i++) begin
            @(negedge CLK);
            drive_a(q[i]);
            #1;
            n_tests++;
            if (outs_a !== q[i].exp) begin
                n_fail++; $display("FAIL branch[%0d]: got %b expected %b", i, outs_a, q[i].exp);
            end
        end
    endtask

    task automatic test_mem_wait();
        row_t q[$];
        repeat (4) q.push_back(mk(0, 1, 0, 1, 0, O_MW));
        q.push_back(mk(0, 1, 0, 1, 1, O_BR));
        q.push_back(mk(0, 0, 0, 0, 0, O_FL));
        q.push_back(mk(0, 0, 0, 0, 0, O_FL));
        q.push_back(mk(0, 0, 0, 0, 0, O_RUN));
        q.push_back(mk(0, 0, 1, 1, 0, O_MW));
        q.push_back(mk(0, 0, 1, 1, 0, O_MW));
        q.push_back(mk(0, 0, 0, 1, 1, O_RUN));
        q.push_back(mk(0, 0, 0, 0, 0, O_RUN));
        for (int i = 0; i < q.size(); i++) begin
            @(negedge CLK);
            drive_a(q[i]);
            #1;
            n_tests++;
            if (outs_a !== q[i].exp) begin
                n_fail++; $display("FAIL mem_wait[%0d]: got %b expected %b", i, outs_a, q[i].exp);
            end
        end
    endtask

    task automatic test_flush_abort();
        row_t q[$];
        q.push_back(mk(0, 1, 0, 0, 0, O_BR));
        q.push_back(mk(0, 0, 0, 1, 0, O_MW));
        q.push_back(mk(0, 0, 0, 1, 0, O_MW));
        q.push_back(mk(0, 0, 0, 1, 1, O_RUN));
        q.push_back(mk(0, 0, 0, 0, 0, O_RUN));
        for (int i = 0; i < q.size(); i++) begin
            @(negedge CLK);
            drive_a(q[i]);
            #1;
            n_tests++;
            if (outs_a !== q[i].exp) begin
                n_fail++; $display("FAIL flush_abort[%0d]: got %b expected %b", i, outs_a, q[i].exp);
            end
        end
    endtask

    task automatic test_timeout();
        row_t q[$];
        repeat (8) q.push_back(mk(0, 0, 0, 1, 0, O_MW));
        q.push_back(mk(0, 0, 0, 1, 0, O_TO));
        q.push_back(mk(0, 0, 0, 1, 0, O_MW));
        q.push_back(mk(0, 0, 0, 1, 1, O_RUN));
        q.push_back(mk(0, 0, 0, 0, 0, O_RUN));
        for (int i = 0; i < q.size(); i++) begin
            @(negedge CLK);
            drive_a(q[i]);
            #1;
            n_tests++;
            if (outs_a !== q[i].exp) begin
                n_fail++; $display("FAIL timeout[%0d]: got %b expected %b", i, outs_a, q[i].exp);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        row_t q[$];
        q.push_back(mk(0, 0, 0, 1, 0, O_MW));
        q.push_back(mk(0, 0, 0, 1, 0, O_MW));
        repeat (9) q.push_back(mk(1, 0, 0, 1, 0, O_RST));
        q.push_back(mk(0, 0, 0, 0, 0, O_RUN));
        q.push_back(mk(0, 0, 0, 0, 0, O_RUN));
        for (int i = 0; i < q.size(); i++) begin
            @(negedge CLK);
            drive_a(q[i]);
            #1;
            n_tests++;
            if (outs_a !== q[i].exp) begin
                n_fail++; $display("FAIL reset_mid_wait[%0d]: got %b expected %b", i, outs_a, q[i].exp);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        row_t q[$];
        q.push_back(mk(0, 1, 0, 0, 0, O_BR));
        q.push_back(mk(1, 0, 0, 0, 0, O_RST));
        q.push_back(mk(0, 0, 0, 0, 0, O_RUN));
        q.push_back(mk(0, 0, 0, 0, 0, O_RUN));
        for (int i = 0; i < q.size(); i++) begin
            @(negedge CLK);
            drive_a(q[i]);
            #1;
            n_tests++;
            if (outs_a !== q[i].exp) begin
                n_fail++; $display("FAIL reset_mid_flush[%0d]: got %b expected %b", i, outs_a, q[i].exp);
            end
        end
    endtask

    task automatic test_stats();
        row_t q[$];
        int   exp_stall[7] = '{0, 1, 1, 2, 3, 3, 3};
        int   exp_flush[7] = '{0, 0, 0, 0, 0, 1, 2};
        q.push_back(mk(0, 0, 1, 0, 0, O_LU));
        q.push_back(mk(0, 0, 0, 0, 0, O_RUN));
        q.push_back(mk(0, 0, 1, 0, 0, O_LU));
        q.push_back(mk(0, 0, 1, 0, 0, O_LU));
        q.push_back(mk(0, 1, 0, 0, 0, O_BR));
        q.push_back(mk(0, 0, 0, 0, 0, O_FL));
        q.push_back(mk(0, 0, 0, 0, 0, O_RUN));
        for (int i = 0; i < q.size(); i++) begin
            @(negedge CLK);
            drive_b(q[i]);
            #1;
            n_tests++;
            if (outs_b !== q[i].exp) begin
                n_fail++; $display("FAIL stats_outs[%0d]: got %b expected %b", i, outs_b, q[i].exp);
            end
`ifdef PIPE_HAZARD_STATS_EN
            n_tests++;
            if (bus_b.stall_count !== 16'(exp_stall[i]) || bus_b.flush_count !== 16'(exp_flush[i])) begin
                n_fail++; $display("FAIL stats_count[%0d]: got stall=%0d flush=%0d expected %0d/%0d",
                                   i, bus_b.stall_count, bus_b.flush_count, exp_stall[i], exp_flush[i]);
            end
`else
            n_tests++;
            if (bus_b.stall_count !== 16'd0 || bus_b.flush_count !== 16'd0) begin
                n_fail++; $display("FAIL stats_tied[%0d]: got stall=%0d flush=%0d expected 0/0 (model %0d/%0d when enabled)",
                                   i, bus_b.stall_count, bus_b.flush_count, exp_stall[i], exp_flush[i]);
            end
`endif
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RESET   = 1'b1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_flush_abort();
        test_timeout();
        test_reset_mid_wait();
        test_reset_mid_flush();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
